// File: rtl/bday_pkg.sv
// -----------------------------------------------------------------------------
// bday_pkg
// Shared definitions for the birthday display path. The display block and the
// sequence checker both take their digits from BDAY_SEQ, so the two can never
// disagree about the birthday.
//   SEQ_LEN  : number of digits in the birthday sequence
//   digit_t  : one BCD digit (values 10..15 are legal on the wire but never
//              equal any sequence entry)
//   BDAY_SEQ : the sequence 2,0,0,1,0,9,2,4 (index 0 is the first digit)
//   state_t  : checker states
// -----------------------------------------------------------------------------
package bday_pkg;

  localparam int SEQ_LEN = 8;
  localparam int IDX_W   = $clog2(SEQ_LEN);

  typedef logic [3:0] digit_t;

  localparam digit_t BDAY_SEQ [SEQ_LEN] = '{
    4'd2, 4'd0, 4'd0, 4'd1, 4'd0, 4'd9, 4'd2, 4'd4
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // True when digit d is the expected sequence entry at position idx.
  function automatic logic is_seq_digit(input logic [IDX_W-1:0] idx,
                                        input digit_t          d);
    return (d == BDAY_SEQ[idx]);
  endfunction

endpackage

// File: rtl/bday_sat_counter.sv
// -----------------------------------------------------------------------------
// bday_sat_counter
// CNT_W-bit incrementer with enable that sticks at all-ones instead of
// wrapping. Used for the completed-sequence count of the checker.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset (clears the count)
//   i_en    : add one this edge (ignored once saturated)
//   o_cnt   : current count, registered
// -----------------------------------------------------------------------------
module bday_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = (r_cnt == {CNT_W{1'b1}});

  // Count enabled events, holding at all-ones once reached.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en && !w_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bday_seq_checker.sv
// -----------------------------------------------------------------------------
// bday_seq_checker
// Watches a stream of 4-bit digits and reports when the full birthday sequence
// (BDAY_SEQ from bday_pkg) arrives in order. Matches never overlap: after the
// last digit the checker spends one cycle in DONE with in_ready low.
// Optional feature macro: BDAY_TIMEOUT_EN -- abort a partial match after
// TIMEOUT consecutive edges without an accepted digit. Without it, timeout is
// tied low and partial matches persist indefinitely.
// Ports:
//   CLK        : clock, rising edge
//   RST_N      : synchronous active-low reset
//   in_valid   : in_digit is valid this cycle
//   in_digit   : BCD digit
//   in_ready   : checker accepts a digit this cycle (low only in DONE)
//   progress   : sequence digits matched so far, 0..SEQ_LEN
//   match      : one-cycle pulse after the final digit is accepted
//   mismatch   : one-cycle pulse after a digit breaks a partial match
//   match_cnt  : completed-sequence count, saturating
//   timeout    : one-cycle pulse on a timeout abort
// -----------------------------------------------------------------------------
module bday_seq_checker
  import bday_pkg::*;
#(
  parameter int SEQ_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  input  logic [3:0]       in_digit,
  output logic             in_ready,
  output logic [3:0]       progress,
  output logic             match,
  output logic             mismatch,
  output logic [CNT_W-1:0] match_cnt,
  output logic             timeout
);

  localparam int LOC_IDX_W = $clog2(SEQ_LEN);

  state_t                 r_state;
  logic [3:0]             r_progress;
  logic                   r_match;
  logic                   r_mismatch;
  logic [LOC_IDX_W-1:0]   w_idx;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_last;
  logic                   w_restart;
  logic                   w_seq_done;

`ifdef BDAY_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic                   r_timeout;
`endif

  assign in_ready   = (r_state != S_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_idx      = r_progress[LOC_IDX_W-1:0];
  assign w_hit      = is_seq_digit(w_idx, in_digit);
  assign w_last     = (r_progress == 4'(SEQ_LEN - 1));
  // Restart only looks at the first sequence digit; no deeper prefix search.
  assign w_restart  = (in_digit == BDAY_SEQ[0]);
  assign w_seq_done = w_accept && w_hit && w_last;

  // Sequence tracking state machine with registered pulse outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_progress <= 4'd0;
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
`ifdef BDAY_TIMEOUT_EN
      r_timeout  <= 1'b0;
      r_tmo_cnt  <= '0;
`endif
    end else begin
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
`ifdef BDAY_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
      case (r_state)
        S_DONE: begin
          r_state    <= S_IDLE;
          r_progress <= 4'd0;
`ifdef BDAY_TIMEOUT_EN
          r_tmo_cnt  <= '0;
`endif
        end
        S_IDLE, S_TRACK: begin
          if (w_accept) begin
`ifdef BDAY_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
            if (w_hit) begin
              r_progress <= r_progress + 4'd1;
              if (w_last) begin
                r_state <= S_DONE;
                r_match <= 1'b1;
              end else begin
                r_state <= S_TRACK;
              end
            end else begin
              // Only a broken partial match is worth flagging.
              r_mismatch <= (r_state == S_TRACK);
              if (w_restart) begin
                r_progress <= 4'd1;
                r_state    <= S_TRACK;
              end else begin
                r_progress <= 4'd0;
                r_state    <= S_IDLE;
              end
            end
          end
`ifdef BDAY_TIMEOUT_EN
          else if (r_state == S_TRACK) begin
            // The TIMEOUT-th idle edge in a row abandons the partial match.
            if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              r_state    <= S_IDLE;
              r_progress <= 4'd0;
              r_timeout  <= 1'b1;
              r_tmo_cnt  <= '0;
            end else begin
              r_tmo_cnt  <= r_tmo_cnt + TMO_W'(1);
            end
          end else begin
            r_tmo_cnt <= '0;
          end
`endif
        end
        default: begin
          r_state    <= S_IDLE;
          r_progress <= 4'd0;
        end
      endcase
    end
  end

  bday_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (w_seq_done),
    .o_cnt   (match_cnt)
  );

  assign progress = r_progress;
  assign match    = r_match;
  assign mismatch = r_mismatch;

`ifdef BDAY_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bday_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_bday_seq_checker
// Self-checking bench for bday_seq_checker. A digit-count model tracks how
// many birthday digits have been matched and what the flags must be; every
// cycle the DUT outputs are compared with it, and directed scenarios pin
// hand-computed values. Digit streams are written as hex words, one digit
// per nibble, most significant nibble first.
// Honors BDAY_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bday_seq_checker;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_digit = 4'd0;
  logic       in_ready;
  logic [3:0] progress;
  logic       match;
  logic       mismatch;
  logic [7:0] match_cnt;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  bday_seq_checker dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_digit  (in_digit),
    .in_ready  (in_ready),
    .progress  (progress),
    .match     (match),
    .mismatch  (mismatch),
    .match_cnt (match_cnt),
    .timeout   (timeout)
  );

  localparam int REF_SEQ [8] = '{2, 0, 0, 1, 0, 9, 2, 4};

  // Model state
  int m_prog = 0;
  bit m_done = 1'b0;
  int m_cnt  = 0;
  bit m_match = 1'b0;
  bit m_mis   = 1'b0;
  bit m_to    = 1'b0;
`ifdef BDAY_TIMEOUT_EN
  int m_idle = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model update on each edge, then compare the DUT shortly after the edge.
  always @(posedge CLK) begin
    if (!RST_N) begin
      m_prog = 0; m_done = 1'b0; m_cnt = 0;
      m_match = 1'b0; m_mis = 1'b0; m_to = 1'b0;
`ifdef BDAY_TIMEOUT_EN
      m_idle = 0;
`endif
    end else begin
      m_match = 1'b0; m_mis = 1'b0; m_to = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
        m_prog = 0;
      end else if (in_valid) begin
`ifdef BDAY_TIMEOUT_EN
        m_idle = 0;
`endif
        if (int'(in_digit) == REF_SEQ[m_prog]) begin
          m_prog++;
          if (m_prog == 8) begin
            m_done = 1'b1;
            m_match = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        end else begin
          m_mis  = (m_prog != 0);
          m_prog = (int'(in_digit) == 2) ? 1 : 0;
        end
      end
`ifdef BDAY_TIMEOUT_EN
      else if (m_prog != 0) begin
        m_idle++;
        if (m_idle == 16) begin
          m_to = 1'b1;
          m_prog = 0;
          m_idle = 0;
        end
      end
`endif
    end
    #1;
    check("cyc_progress",  int'(progress),  m_prog);
    check("cyc_in_ready",  int'(in_ready),  m_done ? 0 : 1);
    check("cyc_match",     int'(match),     int'(m_match));
    check("cyc_mismatch",  int'(mismatch),  int'(m_mis));
    check("cyc_timeout",   int'(timeout),   int'(m_to));
    check("cyc_match_cnt", int'(match_cnt), m_cnt);
  end

  // One cycle of input, returning at the following falling edge.
  task automatic step(input logic v, input logic [3:0] d);
    in_valid = v;
    in_digit = d;
    @(negedge CLK);
  endtask

  // Feed n nibbles of w (most significant first) with gap idle cycles after each.
  task automatic feed(input logic [63:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, w[4*i +: 4]);
      for (int g = 0; g < gap; g++) step(1'b0, 4'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step(1'b1, 4'd2);
    step(1'b1, 4'd2);
    RST_N = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    // Reset: two edges with a valid '2' presented
    do_reset();
    check("rst_progress",  int'(progress),  0);
    check("rst_match_cnt", int'(match_cnt), 0);
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_match",     int'(match),     0);
    check("rst_mismatch",  int'(mismatch),  0);

    // Clean sequence; progress steps 1..8
    for (int i = 7; i >= 0; i--) begin
      logic [31:0] w;
      w = 32'h2001_0924;
      step(1'b1, w[4*i +: 4]);
      check("clean_progress", int'(progress), 8 - i);
    end
    check("clean_match",    int'(match),     1);
    check("clean_cnt",      int'(match_cnt), 1);
    check("clean_ready_lo", int'(in_ready),  0);
    // The '2' offered during DONE must be dropped
    step(1'b1, 4'd2);
    check("done_progress", int'(progress), 0);
    check("done_ready_hi", int'(in_ready), 1);
    check("done_match_lo", int'(match),    0);
    step(1'b0, 4'd0);

    // Mismatch with restart on '2'
    do_reset();
    feed(64'h2002, 4, 0);
    check("restart_mismatch", int'(mismatch), 1);
    check("restart_progress", int'(progress), 1);
    feed(64'h001_0924, 7, 0);
    check("restart_match", int'(match),     1);
    check("restart_cnt",   int'(match_cnt), 1);
    step(1'b0, 4'd0);

    // Gaps of 3 idle cycles between digits
    do_reset();
    feed(64'h2001_0924, 8, 3);
    check("gap_match_cnt", int'(match_cnt), 1);

    // Long gap after 2,0,0
    do_reset();
    feed(64'h200, 3, 0);
`ifdef BDAY_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step(1'b0, 4'd0);
    check("tmo_not_yet",   int'(timeout),  0);
    check("tmo_prog_held", int'(progress), 3);
    step(1'b0, 4'd0);
    check("tmo_pulse",    int'(timeout),  1);
    check("tmo_progress", int'(progress), 0);
    feed(64'h1_0924, 5, 0);
    check("tmo_no_match", int'(match_cnt), 0);
`else
    for (int i = 0; i < 20; i++) step(1'b0, 4'd0);
    check("nogap_prog_held", int'(progress), 3);
    feed(64'h1_0924, 5, 0);
    check("nogap_match", int'(match),     1);
    check("nogap_cnt",   int'(match_cnt), 1);
`endif
    step(1'b0, 4'd0);

    // Non-BCD digit breaks a match; junk in IDLE is silent
    do_reset();
    feed(64'h20F, 3, 0);
    check("junk_mismatch", int'(mismatch), 1);
    check("junk_progress", int'(progress), 0);
    feed(64'h9, 1, 0);
    check("idle_no_mismatch", int'(mismatch), 0);

    // Reset mid-sequence discards the partial match
    do_reset();
    feed(64'h2001, 4, 0);
    RST_N = 1'b0;
    step(1'b0, 4'd0);
    RST_N = 1'b1;
    feed(64'h0924, 4, 0);
    check("midrst_progress", int'(progress),  0);
    check("midrst_cnt",      int'(match_cnt), 0);

    // Saturation: 256 back-to-back sequences
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      feed(64'h2001_0924, 8, 0);
      if (k == 255) check("sat_255", int'(match_cnt), 255);
      if (k == 256) begin
        check("sat_hold",  int'(match_cnt), 255);
        check("sat_pulse", int'(match),     1);
      end
      step(1'b1, 4'd2);
    end
    step(1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
